// File: rtl/berger_scrub_ctrl.sv
// rtl/berger_scrub_ctrl.sv - Berger memory scrub sequencer and error logger
// Walks every address, logs failing words, and passes host writes through with priority.
module berger_scrub_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 host_wr_en,
  input  logic [ADDR_W-1:0]    host_addr,
  input  logic [DATA_W-1:0]    host_data,
  output logic                 mem_wr_en,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_data,
  input  logic [DATA_W-1:0]    mem_rd_data,
  input  logic                 mem_err,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      err_count,
  output logic [2**ADDR_W-1:0] err_map,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic                 first_err_valid
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   scan_cnt;
  logic [3:0]          drain_cnt;
  logic                drain_last;
  logic                issue;
  logic                scan_entry;
  logic                cap_valid;
  logic [ADDR_W-1:0]   cap_addr;

  // Read data only feeds the host read path outside this block.
  logic unused_rd_data;
  assign unused_rd_data = ^mem_rd_data;

  // A host write steals the memory port, so the scan issues nothing that cycle.
  assign issue      = (state == SCAN) && !host_wr_en;
  assign scan_entry = (state == IDLE) && (next_state == SCAN);
  assign drain_last = (drain_cnt == 4'(RD_LAT - 1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SCAN;
      SCAN:    if (issue && (scan_cnt == LAST_ADDR))
                 next_state = (RD_LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (drain_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_wr_en = host_wr_en;
    mem_data  = host_data;
    mem_addr  = host_addr;
    if (!host_wr_en && (state == SCAN)) mem_addr = scan_cnt;
  end

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign cap_valid = issue;
      assign cap_addr  = scan_cnt;
    end else begin : g_pipe
      logic [RD_LAT-1:0] pipe_valid;
      logic [ADDR_W-1:0] pipe_addr [RD_LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < RD_LAT; i++) begin
            pipe_valid[i] <= 1'b0;
            pipe_addr[i]  <= '0;
          end
        end else begin
          pipe_valid[0] <= issue;
          pipe_addr[0]  <= scan_cnt;
          for (int i = 1; i < RD_LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_addr[i]  <= pipe_addr[i-1];
          end
        end
      end

      assign cap_valid = pipe_valid[RD_LAT-1];
      assign cap_addr  = pipe_addr[RD_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      scan_cnt  <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == SCAN) || (next_state == DRAIN);
      done  <= (next_state == DONE);
      if (scan_entry)
        scan_cnt <= '0;
      else if (issue)
        scan_cnt <= scan_cnt + 1'b1;
      if (state == DRAIN)
        drain_cnt <= drain_cnt + 1'b1;
      else
        drain_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count       <= '0;
      err_map         <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
    end else if (scan_entry) begin
      err_count       <= '0;
      err_map         <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
    end else if (cap_valid && mem_err) begin
      err_map[cap_addr] <= 1'b1;
      err_count         <= err_count + 1'b1;
      if (!first_err_valid) begin
        first_err_addr  <= cap_addr;
        first_err_valid <= 1'b1;
      end
    end
  end

endmodule
